ber_checker: RTL and testbench
==============================

Name: ber_checker

Overview:
- Sits directly downstream of the downsampler, one per branch.
- Slices each symbol-rate sample to a hard bit and compares it with the local PRBS reference.
- Finds the channel delay by exhaustive windowed search, then counts bits and errors for BER measurement.

Parameters:
- S_IN, 10, width of the signed input sample (matches downsampler output width S_COEF+S_IN).
- BUF_LEN, 32, number of candidate delays (0..BUF_LEN-1 symbols).
- WIN, 64, symbols per search window.
- CNT_W, 32, width of the bit and error counters.
- DLY_W, $clog2(BUF_LEN), width of the delay index.
- RELOCK_TH, WIN/4, window error threshold for relock (used only with the optional feature).

Ports:
- clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  global enable; when low all state freezes.
- i_valid  in  1  symbol strobe from the downsampler (1 clock in OS).
- i_dwnsmp  in  S_IN  signed downsampled sample.
- i_prbs  in  1  reference PRBS bit, advanced on the same strobe.
- o_locked  out  1  high once the delay has been selected.
- o_delay  out  DLY_W  selected delay.
- o_bit_cnt  out  CNT_W  symbols compared while locked.
- o_err_cnt  out  CNT_W  mismatches while locked.

Behaviour:
- **Event definition:** event = i_enable & i_valid, sampled on the rising clock edge. No state changes without an event.
- **Slicer:** dec = i_dwnsmp[S_IN-1]. Mapping is bit 0 → positive sample, bit 1 → negative sample; a zero sample decides 0.
- **Reference line:**
  - ref is a BUF_LEN-1 bit shift register, cleared on reset; on each event ref <= {ref[BUF_LEN-3:0], i_prbs}.
  - tap(0) = i_prbs; tap(k) = ref[k-1], i.e. the PRBS bit from k events earlier.
  - mismatch(d) = dec ^ tap(d).
- **Reset (i_reset=0, asynchronous):**
  - All outputs are 0.
  - State = SEARCH; d=0, win_cnt=0, err_win=0, min_err=all ones, best=0, ref=0.
- **SEARCH state:**
  - Each event: win_cnt increments and err_win accumulates mismatch(d).
  - On the event where win_cnt==WIN-1, the window total is e = err_win + mismatch(d).
  - If e < min_err (strict), then min_err<=e and best<=d. Ties keep the lower delay.
  - win_cnt and err_win clear, and d increments.
  - If d==BUF_LEN-1 at that event, move to LOCK: o_delay<=final best (including this window), o_locked<=1.
  - Search length is exactly BUF_LEN*WIN events. The first windows see zero-filled ref; this is accepted.
- **LOCK state:**
  - Each event: o_bit_cnt+1 and o_err_cnt+mismatch(o_delay).
  - When o_bit_cnt reaches 2^CNT_W-1, both counters freeze, so the ratio stays consistent.
  - LOCK holds until reset.
- **Timing:** all outputs are registered. Counters and o_locked update on the same edge as the qualifying event and are visible the next cycle. Effective latency from input to counter is 1 clock.
- **i_enable low mid-window:** the window is paused, not restarted.
- **Mid-operation reset:** reset asserted at any time clears everything immediately. After release, the search restarts from d=0.
- **Simultaneous last-window event and LOCK entry:** the first LOCK count happens on the next event, not the transition event.

Optional Feature:
- Macro: BER_CHECKER_RELOCK_EN.
- **Defined:**
  - In LOCK, a window counter of WIN events accumulates the window error count.
  - If a window ends with errors > RELOCK_TH, return to SEARCH with d=0 and min_err=all ones, and drop o_locked the next cycle.
  - o_delay, o_bit_cnt and o_err_cnt hold their values; the counters resume accumulating after the next lock.
- **Undefined:** LOCK is permanent until reset and no window logic is synthesized.

Test Plan:
- **Reset:** i_reset=0 with random inputs → all outputs 0. Releasing reset then pulsing it at event 500 of the search restarts the search; lock occurs exactly 2048 events after the final release.
- **Clean channel:** PRBS9 mapped to ±100, delayed 5 symbols, event every 4th clock → o_locked=1 after 2048 events, o_delay=5. After 1000 further events: o_bit_cnt=1000, o_err_cnt=0.
- **Injected errors:** same as the clean channel, with the sign of every 10th post-lock sample inverted → after 1000 events, o_err_cnt=100.
- **Gating:** i_enable=0 for 37 clocks mid-window with i_valid still toggling → no counter or state change. Lock still occurs after exactly 2048 events.
- **Saturation:** CNT_W=8, locked clean channel for 300 events → o_bit_cnt=255 and stays there; o_err_cnt is frozen.
- **Relock (BER_CHECKER_RELOCK_EN):** locked at delay 5, then channel delay switched to 9 → o_locked falls after the first window with >16 errors, then relocks with o_delay=9 after 2048 more events. o_bit_cnt is held during the search.

Source files
------------

// File: rtl/ber_checker.sv
// ber_checker: slices downsampled samples to hard bits and compares them with a
// delayed local PRBS reference. It searches every candidate delay over one
// window each, locks on the delay with the fewest errors, then counts bits and
// errors for BER measurement.
// Optional feature macro: BER_CHECKER_RELOCK_EN (window-based relock while locked).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_SEARCH| one window per candidate delay, tracking the best delay
// ST_LOCK  | delay fixed, bit/error counters accumulate (saturating)
module ber_checker #(
  parameter int S_IN      = 10,
  parameter int BUF_LEN   = 32,
  parameter int WIN       = 64,
  parameter int CNT_W     = 32,
  parameter int DLY_W     = $clog2(BUF_LEN),
  parameter int RELOCK_TH = WIN/4
) (
  input  logic                   clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_valid,
  input  logic signed [S_IN-1:0] i_dwnsmp,
  input  logic                   i_prbs,
  output logic                   o_locked,
  output logic [DLY_W-1:0]       o_delay,
  output logic [CNT_W-1:0]       o_bit_cnt,
  output logic [CNT_W-1:0]       o_err_cnt
);

  localparam int WC_W = (WIN > 1) ? $clog2(WIN) : 1;
  // Error accumulator must hold a full window and the relock threshold.
  localparam int EW_W = $clog2(((WIN > RELOCK_TH) ? WIN : RELOCK_TH) + 1);

  typedef enum logic {ST_SEARCH, ST_LOCK} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BUF_LEN-2:0] r_ref;
  logic [DLY_W-1:0]   r_d;
  logic [DLY_W-1:0]   r_best;
  logic [WC_W-1:0]    r_win_cnt;
  logic [EW_W-1:0]    r_err_win;
  logic [EW_W-1:0]    r_min_err;

  logic               w_event;
  logic               w_dec;
  logic [BUF_LEN-1:0] w_taps;
  logic               w_mis_srch;
  logic               w_mis_lock;
  logic               w_mis_win;
  logic [EW_W-1:0]    w_err_tot;
  logic               w_win_end;
  logic               w_better;
  logic               w_last_d;
  logic               w_sat;
  logic               w_relock;

  // Event qualification, slicer, delay taps and window arithmetic
  always_comb begin
    w_event    = i_enable & i_valid;
    w_dec      = i_dwnsmp[S_IN-1];
    // Tap 0 is the live PRBS bit, tap k the bit from k events earlier.
    w_taps     = {r_ref, i_prbs};
    w_mis_srch = w_dec ^ w_taps[r_d];
    w_mis_lock = w_dec ^ w_taps[o_delay];
    w_mis_win  = (r_state == ST_LOCK) ? w_mis_lock : w_mis_srch;
    w_err_tot  = r_err_win + EW_W'(w_mis_win);
    w_win_end  = (r_win_cnt == WC_W'(WIN-1));
    w_better   = (w_err_tot < r_min_err);
    w_last_d   = (r_d == DLY_W'(BUF_LEN-1));
    w_sat      = &o_bit_cnt;
`ifdef BER_CHECKER_RELOCK_EN
    w_relock   = w_win_end && (w_err_tot > EW_W'(RELOCK_TH));
`else
    w_relock   = 1'b0;
`endif
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SEARCH: if (w_event && w_win_end && w_last_d) w_state_nxt = ST_LOCK;
      ST_LOCK:   if (w_event && w_relock)              w_state_nxt = ST_SEARCH;
      default:   w_state_nxt = ST_SEARCH;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) r_state <= ST_SEARCH;
    else          r_state <= w_state_nxt;
  end

  // Reference line, delay search and lock-time counters; all frozen without an event
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_ref     <= '0;
      r_d       <= '0;
      r_best    <= '0;
      r_win_cnt <= '0;
      r_err_win <= '0;
      r_min_err <= '1;
      o_locked  <= 1'b0;
      o_delay   <= '0;
      o_bit_cnt <= '0;
      o_err_cnt <= '0;
    end else if (w_event) begin
      r_ref <= {r_ref[BUF_LEN-3:0], i_prbs};
      if (r_state == ST_SEARCH) begin
        if (w_win_end) begin
          r_win_cnt <= '0;
          r_err_win <= '0;
          if (w_better) begin
            r_min_err <= w_err_tot;
            r_best    <= r_d;
          end
          if (w_last_d) begin
            r_d      <= '0;
            o_locked <= 1'b1;
            o_delay  <= w_better ? r_d : r_best;
          end else begin
            r_d <= r_d + DLY_W'(1);
          end
        end else begin
          r_win_cnt <= r_win_cnt + WC_W'(1);
          r_err_win <= w_err_tot;
        end
      end else begin
        // Freeze both counters together so the ratio stays meaningful.
        if (!w_sat) begin
          o_bit_cnt <= o_bit_cnt + CNT_W'(1);
          o_err_cnt <= o_err_cnt + CNT_W'(w_mis_lock);
        end
`ifdef BER_CHECKER_RELOCK_EN
        if (w_win_end) begin
          r_win_cnt <= '0;
          r_err_win <= '0;
          if (w_relock) begin
            o_locked  <= 1'b0;
            r_d       <= '0;
            r_best    <= '0;
            r_min_err <= '1;
          end
        end else begin
          r_win_cnt <= r_win_cnt + WC_W'(1);
          r_err_win <= w_err_tot;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_ber_checker.sv
// Bench for ber_checker: PRBS9 reference, delayed/noisy channel, reference
// model computes the search winner and lock-time counts from recorded history.
module tb_ber_checker;

  localparam int S_IN    = 10;
  localparam int BUF_LEN = 32;
  localparam int WIN     = 64;
  localparam int SRCH    = BUF_LEN * WIN;

  logic                   clock = 1'b0;
  logic                   i_reset;
  logic                   i_enable;
  logic                   i_valid;
  logic signed [S_IN-1:0] i_dwnsmp;
  logic                   i_prbs;
  logic                   o_locked, s_locked;
  logic [4:0]             o_delay, s_delay;
  logic [31:0]            o_bit_cnt, o_err_cnt;
  logic [7:0]             s_bit_cnt, s_err_cnt;

  always #5 clock = ~clock;

  ber_checker #(.S_IN(S_IN), .BUF_LEN(BUF_LEN), .WIN(WIN), .CNT_W(32)) dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_dwnsmp(i_dwnsmp), .i_prbs(i_prbs), .o_locked(o_locked), .o_delay(o_delay),
    .o_bit_cnt(o_bit_cnt), .o_err_cnt(o_err_cnt));

  ber_checker #(.S_IN(S_IN), .BUF_LEN(BUF_LEN), .WIN(WIN), .CNT_W(8)) u_sat (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_dwnsmp(i_dwnsmp), .i_prbs(i_prbs), .o_locked(s_locked), .o_delay(s_delay),
    .o_bit_cnt(s_bit_cnt), .o_err_cnt(s_err_cnt));

  int         n_chk = 0;
  int         n_err = 0;
  bit         dec_h[$];
  bit         prbs_h[$];
  logic [8:0] lfsr = 9'h1FF;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit prbs9_step();
    bit b;
    b    = lfsr[8] ^ lfsr[4];
    lfsr = {lfsr[7:0], b};
    return b;
  endfunction

  // Reference bit k events before event i; zero before the first event after reset.
  function automatic bit tap_m(int i, int d);
    return (i - d >= 0) ? prbs_h[i-d] : 1'b0;
  endfunction

  // Window d covers events d*WIN .. d*WIN+WIN-1; lowest error count wins, ties to lower d.
  function automatic int model_delay();
    int best = 0;
    int min_e = 1 << 30;
    for (int d = 0; d < BUF_LEN; d++) begin
      int e = 0;
      for (int j = d*WIN; j < (d+1)*WIN; j++) e += int'(dec_h[j] ^ tap_m(j, d));
      if (e < min_e) begin
        min_e = e;
        best  = d;
      end
    end
    return best;
  endfunction

  function automatic int model_bits(int limit);
    int n = dec_h.size() - SRCH;
    return (n < limit) ? n : limit;
  endfunction

  function automatic int model_errs(int dly, int limit);
    int e = 0;
    int n = model_bits(limit);
    for (int j = SRCH; j < SRCH + n; j++) e += int'(dec_h[j] ^ tap_m(j, dly));
    return e;
  endfunction

  task automatic apply_reset(input int hold);
    #2 i_reset = 1'b0;
    #1;
    check_val("rst_locked",  o_locked,  0);
    check_val("rst_delay",   o_delay,   0);
    check_val("rst_bit_cnt", o_bit_cnt, 0);
    check_val("rst_err_cnt", o_err_cnt, 0);
    check_val("rst_sat_bit", s_bit_cnt, 0);
    for (int i = 0; i < hold; i++) begin
      i_enable = 1'($urandom_range(1));
      i_valid  = 1'($urandom_range(1));
      i_dwnsmp = S_IN'($urandom);
      i_prbs   = 1'($urandom_range(1));
      @(posedge clock);
      #1;
    end
    check_val("rst_hold_locked", o_locked, 0);
    i_reset = 1'b1;
    dec_h.delete();
    prbs_h.delete();
  endtask

  task automatic gate_clocks(input int n);
    for (int i = 0; i < n; i++) begin
      i_enable = 1'b0;
      i_valid  = 1'(i & 1);
      i_dwnsmp = S_IN'($urandom);
      i_prbs   = 1'($urandom_range(1));
      @(posedge clock);
      #1;
    end
    i_enable = 1'b1;
    i_valid  = 1'b0;
  endtask

  task automatic run_events(input int n, input int dly, input int amp_mode,
                            input int flip_every, input int noise_pct, input int gap);
    for (int e = 0; e < n; e++) begin
      int idx = prbs_h.size();
      int amp, s, k;
      bit p, tx;
      p = prbs9_step();
      if (idx - dly >= 0) tx = (dly == 0) ? p : prbs_h[idx-dly];
      else                tx = 1'($urandom_range(1));
      amp = (amp_mode != 0) ? int'($urandom_range(300)) : 100;
      s   = tx ? -amp : amp;
      k   = idx - SRCH + 1;
      if (flip_every > 0 && k >= 1 && (k % flip_every) == 0) s = -s;
      if (noise_pct > 0 && int'($urandom_range(99)) < noise_pct) s = -s;
      for (int g = 1; g < gap; g++) begin
        i_enable = 1'b1;
        i_valid  = 1'b0;
        i_dwnsmp = S_IN'($urandom);
        i_prbs   = 1'($urandom_range(1));
        @(posedge clock);
        #1;
      end
      i_enable = 1'b1;
      i_valid  = 1'b1;
      i_dwnsmp = S_IN'(s);
      i_prbs   = p;
      @(posedge clock);
      #1;
      i_valid = 1'b0;
      prbs_h.push_back(p);
      dec_h.push_back(s < 0);
    end
  endtask

  task automatic run_scenario(input string tag, input int dly, input int amp_mode,
                              input int flip_every, input int noise_pct, input int gap,
                              input int post, input bit gate, input int exp_dly,
                              input int exp_err);
    int md;
    apply_reset(3);
    if (gate) begin
      run_events(1000, dly, amp_mode, flip_every, noise_pct, gap);
      gate_clocks(37);
      check_val({tag, "_gate_srch_locked"}, o_locked, 0);
      check_val({tag, "_gate_srch_bits"}, o_bit_cnt, 0);
      run_events(SRCH - 1 - 1000, dly, amp_mode, flip_every, noise_pct, gap);
    end else begin
      run_events(SRCH - 1, dly, amp_mode, flip_every, noise_pct, gap);
    end
    check_val({tag, "_prelock"}, o_locked, 0);
    run_events(1, dly, amp_mode, flip_every, noise_pct, gap);
    check_val({tag, "_locked"}, o_locked, 1);
    check_val({tag, "_bits_at_lock"}, o_bit_cnt, 0);
    md = model_delay();
    check_val({tag, "_delay"}, o_delay, md);
    if (exp_dly >= 0) check_val({tag, "_delay_nominal"}, o_delay, exp_dly);
    run_events(post, dly, amp_mode, flip_every, noise_pct, gap);
    if (gate) begin
      gate_clocks(37);
      check_val({tag, "_gate_lock_bits"}, o_bit_cnt, model_bits(1 << 30));
    end
    check_val({tag, "_bit_cnt"}, o_bit_cnt, model_bits(1 << 30));
    check_val({tag, "_bit_cnt_n"}, o_bit_cnt, post);
    check_val({tag, "_err_cnt"}, o_err_cnt, model_errs(md, 1 << 30));
    if (exp_err >= 0) check_val({tag, "_err_cnt_n"}, o_err_cnt, exp_err);
    check_val({tag, "_sat_bits"}, s_bit_cnt, model_bits(255));
    check_val({tag, "_sat_errs"}, s_err_cnt, model_errs(md, 255));
  endtask

  initial begin
    i_reset  = 1'b0;
    i_enable = 1'b0;
    i_valid  = 1'b0;
    i_dwnsmp = '0;
    i_prbs   = 1'b0;
    @(posedge clock);
    #1;
    i_reset = 1'b1;

    // Reset pulse mid-search: search must restart from scratch.
    apply_reset(4);
    run_events(500, 5, 0, 0, 0, 1);
    check_val("mid_search_locked", o_locked, 0);

    // Clean channel with gating and a restart (apply_reset inside).
    run_scenario("clean", 5, 0, 0, 0, 4, 1000, 1'b1, 5, 0);

    // Every 10th post-lock sample inverted.
    run_scenario("inject", 5, 0, 10, 0, 1, 1000, 1'b0, 5, 100);

    // Randomized delays, amplitudes (including zero samples) and noise.
    for (int t = 0; t < 3; t++) begin
      int d  = int'($urandom_range(BUF_LEN - 1));
      int np = int'($urandom_range(5));
      run_scenario($sformatf("rand%0d", t), d, 1, 0, np, 1, 300, 1'b0, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
